mdu_ctrl: RTL and testbench

MDU_CTRL -- requirements
Module: mdu_ctrl

---
 rtl/mdu_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_mdu_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multiply/divide unit sequencer holding architectural HI/LO.
// Latency: mult/multu (and madd/msub) MULT_CYC cycles, div/divu DIV_CYC cycles; mthi/mtlo write on the Start edge.
// Backpressure: Stall freezes the front end while an op is in flight or being issued; Start while Busy is ignored.
// Ports: Clk, Reset (sync, active-low), Start/Op/A/B issue, Flush cancel, IdUse hazard hint,
//        Busy, Stall, HI, LO (registered).
// Optional feature macro: MDU_MADD_EN enables madd (Op 6) / msub (Op 7); otherwise they are no-ops.
module mdu_ctrl #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [2:0]  Op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Flush,
    input  logic        IdUse,
    output logic        Busy,
    output logic        Stall,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    localparam logic [3:0] MULT_CNT = 4'(MULT_CYC);
    localparam logic [3:0] DIV_CNT  = 4'(DIV_CYC);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;
`ifdef MDU_MADD_EN
    localparam logic [2:0] OP_MADD  = 3'd6;
    localparam logic [2:0] OP_MSUB  = 3'd7;
`endif

    logic [0:0]  state;
    logic [3:0]  cnt;
    logic [31:0] res_hi;
    logic [31:0] res_lo;
    logic        res_ok;

    // Datapath evaluated from the operands present with Start
    logic signed [63:0] a_sx;
    logic signed [63:0] b_sx;
    logic [63:0]        prod_s;
    logic [63:0]        prod_u;
    logic [31:0]        abs_a;
    logic [31:0]        abs_b;
    logic [31:0]        sdiv_b;
    logic [31:0]        udiv_b;
    logic [31:0]        mag_q;
    logic [31:0]        mag_r;
    logic [31:0]        sq;
    logic [31:0]        sr;
    logic [31:0]        uq;
    logic [31:0]        ur;
`ifdef MDU_MADD_EN
    logic [63:0]        acc;
`endif

    logic        launch;
    logic [3:0]  load_cnt;
    logic [31:0] nxt_hi;
    logic [31:0] nxt_lo;
    logic        nxt_ok;

    always_comb begin
        a_sx   = {{32{A[31]}}, A};
        b_sx   = {{32{B[31]}}, B};
        prod_s = a_sx * b_sx;
        prod_u = {32'd0, A} * {32'd0, B};

        // Signed division runs on magnitudes so 0x80000000 / -1 wraps cleanly
        // to 0x80000000 instead of relying on signed-overflow behaviour.
        abs_a  = A[31] ? (~A + 32'd1) : A;
        abs_b  = B[31] ? (~B + 32'd1) : B;
        // Divisor forced to 1 on divide-by-zero only to keep the divider
        // well defined; the result is discarded via nxt_ok.
        sdiv_b = (abs_b == 32'd0) ? 32'd1 : abs_b;
        udiv_b = (B == 32'd0) ? 32'd1 : B;
        mag_q  = abs_a / sdiv_b;
        mag_r  = abs_a % sdiv_b;
        sq     = (A[31] ^ B[31]) ? (~mag_q + 32'd1) : mag_q;
        sr     = A[31] ? (~mag_r + 32'd1) : mag_r;
        uq     = A / udiv_b;
        ur     = A % udiv_b;
`ifdef MDU_MADD_EN
        acc    = {HI, LO};
`endif
    end

    always_comb begin
        launch   = 1'b0;
        load_cnt = 4'd0;
        nxt_hi   = HI;
        nxt_lo   = LO;
        nxt_ok   = 1'b1;
        case (Op)
            OP_MULT: begin
                launch   = 1'b1;
                load_cnt = MULT_CNT;
                {nxt_hi, nxt_lo} = prod_s;
            end
            OP_MULTU: begin
                launch   = 1'b1;
                load_cnt = MULT_CNT;
                {nxt_hi, nxt_lo} = prod_u;
            end
            OP_DIV: begin
                launch   = 1'b1;
                load_cnt = DIV_CNT;
                nxt_lo   = sq;
                nxt_hi   = sr;
                nxt_ok   = (B != 32'd0);
            end
            OP_DIVU: begin
                launch   = 1'b1;
                load_cnt = DIV_CNT;
                nxt_lo   = uq;
                nxt_hi   = ur;
                nxt_ok   = (B != 32'd0);
            end
`ifdef MDU_MADD_EN
            // Accumulator is the HI/LO value seen at issue time.
            OP_MADD: begin
                launch   = 1'b1;
                load_cnt = MULT_CNT;
                {nxt_hi, nxt_lo} = acc + prod_s;
            end
            OP_MSUB: begin
                launch   = 1'b1;
                load_cnt = MULT_CNT;
                {nxt_hi, nxt_lo} = acc - prod_s;
            end
`endif
            default: begin
                launch = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state  <= IDLE;
            cnt    <= 4'd0;
            HI     <= 32'd0;
            LO     <= 32'd0;
            res_hi <= 32'd0;
            res_lo <= 32'd0;
            res_ok <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // Flush on the issue cycle means the op never retires.
                    if (Start && !Flush) begin
                        if (launch) begin
                            state  <= RUN;
                            cnt    <= load_cnt;
                            res_hi <= nxt_hi;
                            res_lo <= nxt_lo;
                            res_ok <= nxt_ok;
                        end
                        if (Op == OP_MTHI) HI <= A;
                        if (Op == OP_MTLO) LO <= A;
                    end
                end
                RUN: begin
                    // The final cycle commits even under Flush: the op has
                    // already retired architecturally by then.
                    if (cnt == 4'd1) begin
                        if (res_ok) begin
                            HI <= res_hi;
                            LO <= res_lo;
                        end
                        state <= IDLE;
                        cnt   <= 4'd0;
                    end else if (Flush) begin
                        state <= IDLE;
                        cnt   <= 4'd0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= 4'd0;
                end
            endcase
        end
    end

    assign Busy  = (state == RUN);
    assign Stall = IdUse & (Busy | (Start & (Op != OP_MTHI) & (Op != OP_MTLO)));

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed, table-driven bench for mdu_ctrl with default parameters.
// Latency: inputs driven on the falling edge, outputs sampled on the falling edge.
// Backpressure: a Start while Busy is reported as an error by a monitor.
module tb_mdu_ctrl;

    logic        Clk;
    logic        Reset;
    logic        Start;
    logic [2:0]  Op;
    logic [31:0] A;
    logic [31:0] B;
    logic        Flush;
    logic        IdUse;
    logic        Busy;
    logic        Stall;
    logic [31:0] HI;
    logic [31:0] LO;

    int checks = 0;
    int errors = 0;

    mdu_ctrl #(.MULT_CYC(5), .DIV_CYC(10)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .Start (Start),
        .Op    (Op),
        .A     (A),
        .B     (B),
        .Flush (Flush),
        .IdUse (IdUse),
        .Busy  (Busy),
        .Stall (Stall),
        .HI    (HI),
        .LO    (LO)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Issuing while busy should be impossible when Stall is honoured.
    always @(posedge Clk) begin
        if (Reset && Start && Busy) begin
            errors++;
            $display("FAIL start_in_run: Start seen while Busy=1 at %0t", $time);
        end
    end

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] pre_hi;
        logic [31:0] pre_lo;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          exp_cyc;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Drive one Start pulse; returns at the falling edge after the issue edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        Start = 1'b1;
        Op    = op;
        A     = a;
        B     = b;
        @(negedge Clk);
        Start = 1'b0;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (Busy && n < 40) begin
            n++;
            @(negedge Clk);
        end
    endtask

    task automatic set_hilo(input logic [31:0] h, input logic [31:0] l);
        issue(3'd4, h, 32'd0);
        issue(3'd5, l, 32'd0);
    endtask

    initial begin
        int n;
        Reset = 1'b0;
        Start = 1'b0;
        Op    = 3'd0;
        A     = 32'd0;
        B     = 32'd0;
        Flush = 1'b0;
        IdUse = 1'b0;

        vecs[0]  = '{"mult",      3'd0, 32'hFFFFFFFF, 32'd2,        32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFE, 5};
        vecs[1]  = '{"multu",     3'd1, 32'hFFFFFFFF, 32'd2,        32'd0, 32'd0, 32'h00000001, 32'hFFFFFFFE, 5};
        vecs[2]  = '{"div_m7_2",  3'd2, 32'hFFFFFFF9, 32'd2,        32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[3]  = '{"divu_by0",  3'd3, 32'd5,        32'd0,        32'hAAAA, 32'h5555, 32'hAAAA, 32'h5555, 10};
        vecs[4]  = '{"div_ovf",   3'd2, 32'h80000000, 32'hFFFFFFFF, 32'd1, 32'd1, 32'h00000000, 32'h80000000, 10};
        vecs[5]  = '{"divu_100_7",3'd3, 32'd100,      32'd7,        32'd0, 32'd0, 32'd2,        32'd14,       10};
        vecs[6]  = '{"mult_max",  3'd0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'd0, 32'd0, 32'h3FFFFFFF, 32'h00000001, 5};
        vecs[7]  = '{"div_7_m2",  3'd2, 32'd7,        32'hFFFFFFFE, 32'd0, 32'd0, 32'h00000001, 32'hFFFFFFFD, 10};
`ifdef MDU_MADD_EN
        vecs[8]  = '{"madd",      3'd6, 32'd3,        32'd4,        32'd0, 32'd5, 32'd0,        32'd17,       5};
        vecs[9]  = '{"msub",      3'd7, 32'd3,        32'd4,        32'd0, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF9, 5};
`else
        vecs[8]  = '{"madd_off",  3'd6, 32'd3,        32'd4,        32'd0, 32'd5, 32'd0,        32'd5,        0};
        vecs[9]  = '{"msub_off",  3'd7, 32'd3,        32'd4,        32'd0, 32'd5, 32'd0,        32'd5,        0};
`endif
        vecs[10] = '{"mthi",      3'd4, 32'hDEAD,     32'd0,        32'd1, 32'd2, 32'hDEAD,     32'd2,        0};
        vecs[11] = '{"mtlo",      3'd5, 32'h1234,     32'd0,        32'd1, 32'd2, 32'd1,        32'h1234,     0};

        // Reset for one cycle, then release
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        check("reset_hi", HI, 32'd0);
        check("reset_lo", LO, 32'd0);
        check("reset_busy", {31'd0, Busy}, 32'd0);
        check("reset_stall", {31'd0, Stall}, 32'd0);

        foreach (vecs[i]) begin
            set_hilo(vecs[i].pre_hi, vecs[i].pre_lo);
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            count_busy(n);
            check({vecs[i].name, "_cyc"}, 32'(n), 32'(vecs[i].exp_cyc));
            check({vecs[i].name, "_hi"}, HI, vecs[i].exp_hi);
            check({vecs[i].name, "_lo"}, LO, vecs[i].exp_lo);
        end

        // Stall during div with IdUse held high: Start cycle plus 10 busy cycles
        set_hilo(32'd0, 32'd0);
        IdUse = 1'b1;
        Start = 1'b1;
        Op    = 3'd2;
        A     = 32'hFFFFFFF9;
        B     = 32'd2;
        #1;
        check("stall_at_start", {31'd0, Stall}, 32'd1);
        @(negedge Clk);
        Start = 1'b0;
        n = 0;
        while (Stall && n < 40) begin
            n++;
            @(negedge Clk);
        end
        check("stall_cycles", 32'(n), 32'd10);
        check("stall_div_lo", LO, 32'hFFFFFFFD);
        check("stall_div_hi", HI, 32'hFFFFFFFF);

        // mtlo must not stall even with IdUse
        Start = 1'b1;
        Op    = 3'd5;
        A     = 32'h1234;
        #1;
        check("mtlo_no_stall", {31'd0, Stall}, 32'd0);
        @(negedge Clk);
        Start = 1'b0;
        check("mtlo_lo", LO, 32'h1234);
        check("mtlo_busy", {31'd0, Busy}, 32'd0);
        IdUse = 1'b0;

        // Flush during the third busy cycle of a mult
        set_hilo(32'h11, 32'h22);
        issue(3'd0, 32'd3, 32'd4);
        @(negedge Clk);
        @(negedge Clk);
        Flush = 1'b1;
        @(negedge Clk);
        Flush = 1'b0;
        check("flush_busy", {31'd0, Busy}, 32'd0);
        repeat (6) @(negedge Clk);
        check("flush_hi", HI, 32'h11);
        check("flush_lo", LO, 32'h22);

        // Flush together with Start: op not accepted
        Flush = 1'b1;
        issue(3'd0, 32'd3, 32'd4);
        Flush = 1'b0;
        check("flush_start_busy", {31'd0, Busy}, 32'd0);
        repeat (6) @(negedge Clk);
        check("flush_start_lo", LO, 32'h22);

        // Flush on the commit cycle: result still lands
        issue(3'd0, 32'd3, 32'd4);
        repeat (4) @(negedge Clk);
        check("flush_commit_busy_last", {31'd0, Busy}, 32'd1);
        Flush = 1'b1;
        @(negedge Clk);
        Flush = 1'b0;
        check("flush_commit_busy", {31'd0, Busy}, 32'd0);
        check("flush_commit_hi", HI, 32'd0);
        check("flush_commit_lo", LO, 32'd12);

        // Reset in the middle of a divide discards it
        set_hilo(32'h77, 32'h88);
        issue(3'd3, 32'd100, 32'd7);
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        Reset = 1'b1;
        check("rst_mid_busy", {31'd0, Busy}, 32'd0);
        check("rst_mid_hi", HI, 32'd0);
        check("rst_mid_lo", LO, 32'd0);
        repeat (12) @(negedge Clk);
        check("rst_mid_lo_late", LO, 32'd0);

        // Reset wins over a simultaneous Start
        Reset = 1'b0;
        issue(3'd5, 32'h55, 32'd0);
        Reset = 1'b1;
        check("rst_prio_lo", LO, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
